// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DEF_WIDTH : default operand/result width
//   state_t   : controller states (IDLE=0, RUN=1, FIX=2, DONE=3)
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_in  : partial remainder before the step
//   bit_in  : next dividend bit shifted into the partial remainder
//   divisor : magnitude of the divisor
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by this step (1 = subtraction kept)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_msb;

    assign shifted = {rem_in, bit_in};

    // a + ~b + 1, zero-extended by one bit so the top bit is the carry-out;
    // carry-out set means no borrow, i.e. shifted >= divisor.
    assign diff = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};

    assign q_bit   = diff[WIDTH+1];
    // When the subtraction is kept the difference is below the divisor,
    // so its bit WIDTH is always zero.
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency sequential restoring divider, signed or unsigned.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : request a division (sampled only in IDLE)
//   is_signed          : 1 = two's-complement, 0 = unsigned
//   dividend, divisor  : operands, captured with start
//   busy               : operation in progress (RUN and FIX)
//   done               : one-cycle pulse, results valid
//   quotient/remainder : results, held until the next completion
//   div_by_zero        : last completed operation had a zero divisor
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;   // partial remainder
    logic [WIDTH-1:0] quo_sh;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvsr;       // divisor magnitude
    logic [WIDTH-1:0] dvd_orig;   // untouched dividend, returned on divide-by-zero
    logic             neg_q, neg_r, dz;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (part_rem),
        .bit_in  (quo_sh[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            part_rem    <= '0;
            quo_sh      <= '0;
            dvsr        <= '0;
            dvd_orig    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    dvd_orig <= dividend;
                    dz       <= (divisor == '0);
                    quo_sh   <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvsr     <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r    <= is_signed && dividend[WIDTH-1];
                    part_rem <= '0;
                    count    <= CW'(WIDTH);
                end
                RUN: begin
                    part_rem <= step_rem;
                    quo_sh   <= {quo_sh[WIDTH-2:0], step_q};
                    count    <= count - CW'(1);
                end
                // Results land on the FIX->DONE edge so they are first
                // visible together with the done pulse.
                FIX: begin
                    div_by_zero <= dz;
                    if (dz) begin
                        // Sign fix-up is skipped: the iterations would give
                        // |dividend| and possibly a negated all-ones quotient.
                        quotient  <= '1;
                        remainder <= dvd_orig;
                    end else begin
                        quotient  <= neg_q ? -quo_sh   : quo_sh;
                        remainder <= neg_r ? -part_rem : part_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operand values.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        z = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one operation and checks the whole timeline:
    // busy window N+1..N+WIDTH+1 with results held, done at N+WIDTH+2, idle after.
    // mode 0: quiet inputs, 1: random start/operand noise while busy and in DONE,
    // mode 2: a 50/5 start injected in cycle N+5.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int mode, input string name,
                          output logic [31:0] oq, output logic [31:0] orr, output logic oz);
        logic [31:0] eq, er, pq, pr;
        logic        ez, pz;
        bit          ok;
        int          bad_k;
        model(a, b, s, eq, er, ez);
        @(negedge clk);
        pq = quotient; pr = remainder; pz = div_by_zero;
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
        ok = 1; bad_k = 0;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (busy !== 1'b1 || done !== 1'b0 || quotient !== pq ||
                remainder !== pr || div_by_zero !== pz) begin
                if (ok) bad_k = k;
                ok = 0;
            end
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                dividend = $urandom; divisor = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (k == 5) begin
                    start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
                end else begin
                    start = 1'b0;
                end
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s busy_window: first bad cycle N+%0d, required busy=1 done=0 and results held", name, bad_k);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_cycle: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        end
        total++;
        if (quotient !== eq) begin
            bad++;
            $display("FAIL %s quotient: got %h required %h", name, quotient, eq);
        end
        total++;
        if (remainder !== er) begin
            bad++;
            $display("FAIL %s remainder: got %h required %h", name, remainder, er);
        end
        total++;
        if (div_by_zero !== ez) begin
            bad++;
            $display("FAIL %s div_by_zero: got %b required %b", name, div_by_zero, ez);
        end
        oq = quotient; orr = remainder; oz = div_by_zero;
        // A start in the DONE cycle must be ignored.
        if (mode == 1) start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b q=%h r=%h, required done=0 busy=0 q=%h r=%h",
                     name, done, busy, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] q, r;
        logic        z;
        run_op(32'd100, 32'd7, 1'b0, 0, "unsigned_100_7", q, r, z);
        total++;
        if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
            bad++;
            $display("FAIL unsigned_100_7_const: q=%0d r=%0d dz=%b, required 14 2 0", q, r, z);
        end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "signed_m7_2", q, r, z);
        total++;
        if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || z !== 1'b0) begin
            bad++;
            $display("FAIL signed_m7_2_const: q=%h r=%h dz=%b, required fffffffd ffffffff 0", q, r, z);
        end
        run_op(32'd5, 32'd0, 1'b0, 0, "div_zero_5", q, r, z);
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1) begin
            bad++;
            $display("FAIL div_zero_5_const: q=%h r=%h dz=%b, required ffffffff 5 1", q, r, z);
        end
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0, "div_zero_signed_neg", q, r, z);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "overflow", q, r, z);
        total++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0) begin
            bad++;
            $display("FAIL overflow_const: q=%h r=%h dz=%b, required 80000000 0 0", q, r, z);
        end
    endtask

    task automatic test_abort();
        logic [31:0] q, r;
        logic        z;
        @(negedge clk);
        start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'd1; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        // Restart right away; its busy window also covers the cycle where the
        // aborted operation would have finished.
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "after_abort", q, r, z);
    endtask

    task automatic test_rst_priority();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd3; is_signed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_priority: busy=%b done=%b, required 0 0 (start ignored under reset)", busy, done);
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] q, r;
        logic        z;
        run_op(32'd9, 32'd3, 1'b0, 2, "busy_start", q, r, z);
        total++;
        if (q !== 32'd3 || r !== 32'd0) begin
            bad++;
            $display("FAIL busy_start_const: q=%0d r=%0d, required 3 0", q, r);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r;
        logic        s, z;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, 1, "random", q, r, z);
            if (b != 32'd0) begin
                total++;
                if (32'(q * b + r) !== a) begin
                    bad++;
                    $display("FAIL random_identity: a=%h b=%h s=%b q=%h r=%h", a, b, s, q, r);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r;
        logic        z;
        run_op(32'd1000, 32'd10, 1'b0, 0, "b2b_0", q, r, z);
        run_op(32'hFFFF_FC18, 32'd7, 1'b1, 0, "b2b_1", q, r, z);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "b2b_2", q, r, z);
        run_op(32'd3, 32'd9, 1'b0, 0, "b2b_3", q, r, z);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_rst_priority();
        test_busy_start();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
